// File: rtl/score_pkg.sv
// Shared encodings for the score display controller: FSM states, side codes, blank digit
// and BCD helpers.
package score_pkg;

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  typedef enum logic {SideLeft = 1'b0, SideRight = 1'b1} side_e;

  localparam logic [3:0] BLANK = 4'hF;

  function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

  // Leading-zero blanking for a tens digit.
  function automatic logic [3:0] tens_disp(input logic [3:0] tens);
    return (tens == 4'd0) ? BLANK : tens;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter with synchronous clear and increment, saturating at 99.
// The next-state digits are exported so the display can register them on the same edge.
module bcd2_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [3:0] tens_nxt,
  output logic [3:0] units_nxt
);

  logic [3:0] tens_q, units_q;

  always_comb begin
    tens_nxt  = tens_q;
    units_nxt = units_q;
    if (clr) begin
      tens_nxt  = 4'd0;
      units_nxt = 4'd0;
    end else if (inc && !(tens_q == 4'd9 && units_q == 4'd9)) begin
      if (units_q == 4'd9) begin
        units_nxt = 4'd0;
        tens_nxt  = tens_q + 4'd1;
      end else begin
        units_nxt = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_nxt;
      units_q <= units_nxt;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Two-player score keeper: arbitrates point pulses, runs the IDLE/PLAY/OVER game FSM and
// drives four registered BCD digits, blinking the winner's score once the game is over.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE  = 11,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       game_over,
  output logic       winner
);

  localparam logic [6:0] WinM1 = 7'(WIN_SCORE - 1);

  state_e                state_q, state_d;
  side_e                 last_q, last_d;
  side_e                 winner_q, winner_d;
  logic                  pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  game_over_q;
  logic [3:0]            dig3_q, dig2_q, dig1_q, dig0_q;
  logic [3:0]            dig3_d, dig2_d, dig1_d, dig0_d;

  logic       req_l, req_r, grant_l, grant_r, win;
  logic [3:0] l_tens, l_units, l_tens_nxt, l_units_nxt;
  logic [3:0] r_tens, r_units, r_tens_nxt, r_units_nxt;

  bcd2_counter u_left (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .inc       (grant_l),
    .tens      (l_tens),
    .units     (l_units),
    .tens_nxt  (l_tens_nxt),
    .units_nxt (l_units_nxt)
  );

  bcd2_counter u_right (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .inc       (grant_r),
    .tens      (r_tens),
    .units     (r_units),
    .tens_nxt  (r_tens_nxt),
    .units_nxt (r_units_nxt)
  );

  // Arbitration: one grant per cycle, ties go to the side not granted last.
  always_comb begin
    req_l    = p1_point | pend_l_q;
    req_r    = p2_point | pend_r_q;
    grant_l  = 1'b0;
    grant_r  = 1'b0;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    last_d   = last_q;
    if (state_q != StPlay || start) begin
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end else begin
      if (req_l && req_r) begin
        if (last_q == SideRight) begin
          grant_l  = 1'b1;
          pend_r_d = 1'b1;
        end else begin
          grant_r  = 1'b1;
          pend_l_d = 1'b1;
        end
      end else if (req_l) begin
        grant_l = 1'b1;
      end else if (req_r) begin
        grant_r = 1'b1;
      end
      if (grant_l) begin
        pend_l_d = 1'b0;
        last_d   = SideLeft;
      end
      if (grant_r) begin
        pend_r_d = 1'b0;
        last_d   = SideRight;
      end
    end
    win = (grant_l && bcd_value(l_tens, l_units) == WinM1) ||
          (grant_r && bcd_value(r_tens, r_units) == WinM1);
    if (win) begin
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    unique case (state_q)
      StIdle: if (start) state_d = StPlay;
      StPlay: begin
        if (!start && win) begin
          state_d  = StOver;
          winner_d = grant_r ? SideRight : SideLeft;
        end
      end
      StOver: if (start) state_d = StPlay;
      default: state_d = StIdle;
    endcase
    if (state_d == StOver) begin
      blink_d = (state_q == StOver) ? blink_q + BLINK_BITS'(1) : '0;
    end else begin
      blink_d = '0;
    end
  end

  // Digits are built from next-state values so a grant shows up on the very next edge.
  always_comb begin
    dig3_d = BLANK;
    dig2_d = BLANK;
    dig1_d = BLANK;
    dig0_d = BLANK;
    if (state_d != StIdle) begin
      dig3_d = tens_disp(l_tens_nxt);
      dig2_d = l_units_nxt;
      dig1_d = tens_disp(r_tens_nxt);
      dig0_d = r_units_nxt;
      if (state_d == StOver && blink_d[BLINK_BITS-1]) begin
        if (winner_d == SideLeft) begin
          dig3_d = BLANK;
          dig2_d = BLANK;
        end else begin
          dig1_d = BLANK;
          dig0_d = BLANK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q      <= SideRight;
      winner_q    <= SideLeft;
      pend_l_q    <= 1'b0;
      pend_r_q    <= 1'b0;
      blink_q     <= '0;
      game_over_q <= 1'b0;
      dig3_q      <= BLANK;
      dig2_q      <= BLANK;
      dig1_q      <= BLANK;
      dig0_q      <= BLANK;
    end else begin
      last_q      <= last_d;
      winner_q    <= winner_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      blink_q     <= blink_d;
      game_over_q <= (state_d == StOver);
      dig3_q      <= dig3_d;
      dig2_q      <= dig2_d;
      dig1_q      <= dig1_d;
      dig0_q      <= dig0_d;
    end
  end

  assign dig3      = dig3_q;
  assign dig2      = dig2_q;
  assign dig1      = dig1_q;
  assign dig0      = dig0_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule
